reg_port_arbiter: RTL and testbench

//  Shares the 2-read/1-write Registers bank between the shader core and the host debug/loader port.

---
 rtl/gpu_regs_pkg.sv | 19 +
 rtl/host_wait_counter.sv | 27 ++
 rtl/reg_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_reg_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_regs_pkg.sv
// rtl/gpu_regs_pkg.sv - shared types and widths for the register-bank port arbiter
package gpu_regs_pkg;

    localparam int unsigned REG_ADDR_WIDTH   = 5;
    localparam int unsigned REG_WORD_WIDTH   = 32;
    localparam int unsigned WAIT_COUNT_WIDTH = 4;

    typedef enum logic {
        CORE_PRI = 1'b0,
        HOST_PRI = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } rsp_tag_t;

endpackage

// File: rtl/host_wait_counter.sv
// rtl/host_wait_counter.sv - saturating count of consecutive host stall cycles
module host_wait_counter
    import gpu_regs_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        inc,
    output logic [WAIT_COUNT_WIDTH-1:0] count,
    output logic                        reached
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WAIT_COUNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign reached = (count == WAIT_COUNT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/reg_port_arbiter.sv
// rtl/reg_port_arbiter.sv - core/host arbiter in front of the 2R/1W register bank
module reg_port_arbiter
    import gpu_regs_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = REG_WORD_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     core_rd_valid,
    output logic                     core_rd_ready,
    input  logic [ADDRESS_WIDTH-1:0] core_rs1,
    input  logic [ADDRESS_WIDTH-1:0] core_rs2,
    output logic                     core_rsp_valid,
    output logic [WORD_WIDTH-1:0]    core_rs1_data,
    output logic [WORD_WIDTH-1:0]    core_rs2_data,
    input  logic                     core_wr_valid,
    output logic                     core_wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] core_rd,
    input  logic [WORD_WIDTH-1:0]    core_wr_data,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     host_write,
    input  logic [ADDRESS_WIDTH-1:0] host_address,
    input  logic [WORD_WIDTH-1:0]    host_wdata,
    output logic                     host_rsp_valid,
    output logic [WORD_WIDTH-1:0]    host_rdata,
    output logic                     rf_write,
    output logic [ADDRESS_WIDTH-1:0] rf_write_address,
    output logic [WORD_WIDTH-1:0]    rf_write_data,
    output logic                     rf_read1,
    output logic [ADDRESS_WIDTH-1:0] rf_read1_address,
    input  logic [WORD_WIDTH-1:0]    rf_read1_data,
    output logic                     rf_read2,
    output logic [ADDRESS_WIDTH-1:0] rf_read2_address,
    input  logic [WORD_WIDTH-1:0]    rf_read2_data
);

    arb_state_t                  state, state_next;
    logic [WAIT_COUNT_WIDTH-1:0] wait_count;
    logic                        wait_reached;
    logic host_rd_req, host_wr_req, host_pri;
    logic core_rd_acc, core_wr_acc, host_rd_acc, host_wr_acc;

    rsp_tag_t                rsp1_tag;
    logic                    rsp1_zero, rsp1_byp, rsp2_zero, rsp2_byp;
    logic [WORD_WIDTH-1:0]   rsp1_byp_data, rsp2_byp_data, port1_data, port2_data;

    assign host_rd_req = host_valid && !host_write;
    assign host_wr_req = host_valid && host_write;
    assign host_pri    = (state == HOST_PRI);

    // Host only contends for the resource it actually needs; the other side proceeds freely.
    assign core_rd_ready = core_rd_valid && !(host_pri && host_rd_req);
    assign core_wr_ready = core_wr_valid && !(host_pri && host_wr_req);
    assign host_ready    = host_valid && (host_pri ||
                           !((host_rd_req && core_rd_valid) || (host_wr_req && core_wr_valid)));

    assign core_rd_acc = core_rd_ready;
    assign core_wr_acc = core_wr_ready;
    assign host_rd_acc = host_ready && !host_write;
    assign host_wr_acc = host_ready && host_write;

    host_wait_counter #(.LIMIT(HOST_MAX_WAIT)) u_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!host_valid || host_ready),
        .inc     (host_valid && !host_ready),
        .count   (wait_count),
        .reached (wait_reached)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= CORE_PRI;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CORE_PRI: if (host_valid && !host_ready && wait_reached) state_next = HOST_PRI;
            HOST_PRI: if (host_ready || !host_valid) state_next = CORE_PRI;
            default:  state_next = CORE_PRI;
        endcase
    end

    // Writes to x0 are accepted but never reach the bank.
    always_comb begin
        rf_write         = 1'b0;
        rf_write_address = '0;
        rf_write_data    = '0;
        if (core_wr_acc) begin
            rf_write         = (core_rd != '0);
            rf_write_address = core_rd;
            rf_write_data    = core_wr_data;
        end else if (host_wr_acc) begin
            rf_write         = (host_address != '0);
            rf_write_address = host_address;
            rf_write_data    = host_wdata;
        end
    end

    always_comb begin
        rf_read1         = core_rd_acc || host_rd_acc;
        rf_read1_address = core_rd_acc ? core_rs1 : (host_rd_acc ? host_address : '0);
        rf_read2         = core_rd_acc;
        rf_read2_address = core_rd_acc ? core_rs2 : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp1_tag      <= NONE;
            rsp1_zero     <= 1'b0;
            rsp1_byp      <= 1'b0;
            rsp1_byp_data <= '0;
            rsp2_zero     <= 1'b0;
            rsp2_byp      <= 1'b0;
            rsp2_byp_data <= '0;
        end else begin
            rsp1_tag      <= core_rd_acc ? CORE : (host_rd_acc ? HOST : NONE);
            rsp1_zero     <= (rf_read1_address == '0);
            rsp1_byp      <= rf_write && (rf_read1_address == rf_write_address);
            rsp1_byp_data <= rf_write_data;
            rsp2_zero     <= (rf_read2_address == '0);
            rsp2_byp      <= rf_write && (rf_read2_address == rf_write_address);
            rsp2_byp_data <= rf_write_data;
        end
    end

    assign port1_data = rsp1_zero ? '0 : (rsp1_byp ? rsp1_byp_data : rf_read1_data);
    assign port2_data = rsp2_zero ? '0 : (rsp2_byp ? rsp2_byp_data : rf_read2_data);

    assign core_rsp_valid = (rsp1_tag == CORE);
    assign host_rsp_valid = (rsp1_tag == HOST);
    assign core_rs1_data  = core_rsp_valid ? port1_data : '0;
    assign core_rs2_data  = core_rsp_valid ? port2_data : '0;
    assign host_rdata     = host_rsp_valid ? port1_data : '0;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb/tb_reg_port_arbiter.sv - directed self-checking bench for reg_port_arbiter
module tb_reg_port_arbiter;
    import gpu_regs_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        core_rd_valid, core_rd_ready, core_rsp_valid;
    logic [4:0]  core_rs1, core_rs2, core_rd;
    logic [31:0] core_rs1_data, core_rs2_data, core_wr_data;
    logic        core_wr_valid, core_wr_ready;
    logic        host_valid, host_ready, host_write, host_rsp_valid;
    logic [4:0]  host_address;
    logic [31:0] host_wdata, host_rdata;
    logic        rf_write, rf_read1, rf_read2;
    logic [4:0]  rf_write_address, rf_read1_address, rf_read2_address;
    logic [31:0] rf_write_data, rf_read1_data, rf_read2_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    reg_port_arbiter #(.HOST_MAX_WAIT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready),
        .core_rs1(core_rs1), .core_rs2(core_rs2),
        .core_rsp_valid(core_rsp_valid), .core_rs1_data(core_rs1_data), .core_rs2_data(core_rs2_data),
        .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
        .core_rd(core_rd), .core_wr_data(core_wr_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
        .host_address(host_address), .host_wdata(host_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
        .rf_write(rf_write), .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
        .rf_read1(rf_read1), .rf_read1_address(rf_read1_address), .rf_read1_data(rf_read1_data),
        .rf_read2(rf_read2), .rf_read2_address(rf_read2_address), .rf_read2_data(rf_read2_data)
    );

    // Register bank stand-in: synchronous write, registered read of the pre-write contents.
    logic [31:0] mem [32];
    always @(posedge clock) begin
        if (rf_read1) rf_read1_data <= mem[rf_read1_address];
        if (rf_read2) rf_read2_data <= mem[rf_read2_address];
        if (rf_write) mem[rf_write_address] <= rf_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        core_rd_valid = 0; core_rs1 = 0; core_rs2 = 0;
        core_wr_valid = 0; core_rd = 0; core_wr_data = 0;
        host_valid = 0; host_write = 0; host_address = 0; host_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [31:0] crv, rs1, rs2, cwv, rd, cwd, hv, hw, ha, hwd;
        logic [31:0] e_crr, e_cwr, e_hr, e_rfw;
        logic [31:0] e_crsp, e_rs1, e_rs2, e_hrsp, e_hrd;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] pre_addr [6];
    logic [31:0] pre_data [6];
    int accepted_at;

    initial begin
        vecs[0] = '{0,0,0, 0,0,0,     1,0,5,0,       0,0,1,0, 0,0,0,1,'h1234};
        vecs[1] = '{1,1,2, 0,0,0,     0,0,0,0,       1,0,0,0, 1,'h11,'h22,0,0};
        vecs[2] = '{0,0,0, 1,7,'hAA,  1,0,7,0,       0,1,1,1, 0,0,0,1,'hAA};
        vecs[3] = '{1,7,0, 0,0,0,     0,0,0,0,       1,0,0,0, 1,'hAA,0,0,0};
        vecs[4] = '{0,0,0, 0,0,0,     1,1,0,'hFFFF,  0,0,1,0, 0,0,0,0,0};
        vecs[5] = '{1,0,5, 0,0,0,     0,0,0,0,       1,0,0,0, 1,0,'h1234,0,0};
        vecs[6] = '{1,3,3, 1,3,'h99,  0,0,0,0,       1,1,0,1, 1,'h99,'h99,0,0};
        vecs[7] = '{1,1,2, 0,0,0,     1,1,2,'h5555,  1,0,1,1, 1,'h11,'h5555,0,0};
        vecs[8] = '{0,0,0, 0,0,0,     1,0,2,0,       0,0,1,0, 0,0,0,1,'h5555};
        pre_addr = '{5, 1, 2, 3, 7, 4};
        pre_data = '{'h1234, 'h11, 'h22, 'h33, 'h77, 'h44};

        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_core_rsp_valid", 32'(core_rsp_valid), 0);
        chk("rst_host_rsp_valid", 32'(host_rsp_valid), 0);
        chk("rst_rf_strobes", {29'd0, rf_write, rf_read1, rf_read2}, 0);
        chk("rst_data", core_rs1_data | core_rs2_data | host_rdata, 0);
        chk("rst_state", 32'(dut.state), 32'(CORE_PRI));
        next_cycle();
        reset_n = 1;

        for (int i = 0; i < 6; i++) begin
            host_valid = 1; host_write = 1;
            host_address = 5'(pre_addr[i]); host_wdata = pre_data[i];
            @(negedge clock);
            chk($sformatf("pre%0d_host_ready", i), 32'(host_ready), 1);
            chk($sformatf("pre%0d_rf_write", i), 32'(rf_write), 1);
            next_cycle();
        end
        idle();
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            core_rd_valid = vecs[i].crv[0]; core_rs1 = 5'(vecs[i].rs1); core_rs2 = 5'(vecs[i].rs2);
            core_wr_valid = vecs[i].cwv[0]; core_rd = 5'(vecs[i].rd); core_wr_data = vecs[i].cwd;
            host_valid = vecs[i].hv[0]; host_write = vecs[i].hw[0];
            host_address = 5'(vecs[i].ha); host_wdata = vecs[i].hwd;
            @(negedge clock);
            chk($sformatf("v%0d_core_rd_ready", i), 32'(core_rd_ready), vecs[i].e_crr);
            chk($sformatf("v%0d_core_wr_ready", i), 32'(core_wr_ready), vecs[i].e_cwr);
            chk($sformatf("v%0d_host_ready", i), 32'(host_ready), vecs[i].e_hr);
            chk($sformatf("v%0d_rf_write", i), 32'(rf_write), vecs[i].e_rfw);
            next_cycle();
            idle();
            @(negedge clock);
            chk($sformatf("v%0d_core_rsp_valid", i), 32'(core_rsp_valid), vecs[i].e_crsp);
            chk($sformatf("v%0d_core_rs1_data", i), core_rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d_core_rs2_data", i), core_rs2_data, vecs[i].e_rs2);
            chk($sformatf("v%0d_host_rsp_valid", i), 32'(host_rsp_valid), vecs[i].e_hrsp);
            chk($sformatf("v%0d_host_rdata", i), host_rdata, vecs[i].e_hrd);
            next_cycle();
        end

        // Host starvation limit: core read held, host read x3 held.
        core_rd_valid = 1; core_rs1 = 1; core_rs2 = 2;
        host_valid = 1; host_write = 0; host_address = 3;
        accepted_at = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 3) chk("t2_core_b2b_rs2", core_rs2_data, 'h5555);
            if (host_ready) begin
                accepted_at = c;
                chk("t2_core_stalled", 32'(core_rd_ready), 0);
                chk("t2_state_host_pri", 32'(dut.state), 32'(HOST_PRI));
                break;
            end
            next_cycle();
        end
        chk("t2_host_accept_cycle", 32'(accepted_at), 5);
        next_cycle();
        host_valid = 0;
        @(negedge clock);
        chk("t2_host_rsp_valid", 32'(host_rsp_valid), 1);
        chk("t2_host_rdata", host_rdata, 'h99);
        chk("t2_core_rsp_gap", 32'(core_rsp_valid), 0);
        chk("t2_core_resumes", 32'(core_rd_ready), 1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("t2_core_rsp_after", core_rs1_data, 'h11);
        next_cycle();

        // Core and host write the same register; core first, host next cycle.
        core_wr_valid = 1; core_rd = 4; core_wr_data = 1;
        host_valid = 1; host_write = 1; host_address = 4; host_wdata = 2;
        @(negedge clock);
        chk("t5_core_wr_ready", 32'(core_wr_ready), 1);
        chk("t5_host_blocked", 32'(host_ready), 0);
        chk("t5_first_write", rf_write_data, 1);
        next_cycle();
        core_wr_valid = 0;
        @(negedge clock);
        chk("t5_host_ready", 32'(host_ready), 1);
        chk("t5_second_write", rf_write_data, 2);
        next_cycle();
        host_write = 0;
        next_cycle();
        idle();
        @(negedge clock);
        chk("t5_final_x4", host_rdata, 2);
        next_cycle();

        // Reset while a core response is in flight and the host wait counter is non-zero.
        core_rd_valid = 1; core_rs1 = 1; core_rs2 = 2;
        host_valid = 1; host_write = 0; host_address = 3;
        next_cycle();
        @(negedge clock);
        chk("t6_count_before", 32'(dut.wait_count), 1);
        chk("t6_core_accept", 32'(core_rd_ready), 1);
        reset_n = 0;
        #1;
        idle();
        chk("t6_count_reset", 32'(dut.wait_count), 0);
        next_cycle();
        chk("t6_core_rsp_dropped", 32'(core_rsp_valid), 0);
        chk("t6_state", 32'(dut.state), 32'(CORE_PRI));
        reset_n = 1;
        @(negedge clock);
        chk("t6_core_rsp_after", 32'(core_rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
